// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter multiplexing NB_CLIENTS request ports onto one single-port external memory.
// Optional bandwidth counters are built when EXT_MEM_BW_COUNT_EN is defined.
module ext_mem_arbiter #(
    parameter int unsigned NB_CLIENTS   = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic [NB_CLIENTS-1:0]            req_valid,
    output logic [NB_CLIENTS-1:0]            req_ready,
    input  logic [NB_CLIENTS-1:0]            req_write,
    input  logic [NB_CLIENTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_CLIENTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NB_CLIENTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             mem_en,
    output logic                             mem_write_en,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_din,
    input  logic [DATA_WIDTH-1:0]            mem_qout,
    input  logic                             bw_clear,
    output logic [CNT_WIDTH-1:0]             bw_read_words,
    output logic [CNT_WIDTH-1:0]             bw_write_words
);

    localparam int unsigned IdxW = (NB_CLIENTS > 1) ? $clog2(NB_CLIENTS) : 1;

    logic [IdxW-1:0]       ptr_q, ptr_d, gnt_idx;
    logic                  gnt_any;
    logic [NB_CLIENTS-1:0] grant;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  mem_en_q, mem_write_en_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_din_q;

    logic [READ_LATENCY:0] vld_q;
    logic [IdxW-1:0]       tag_q [READ_LATENCY+1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Two passes: clients at or above the pointer first, then the wrap-around.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned i = 0; i < NB_CLIENTS; i++) begin
            if (!gnt_any && req_valid[i] && (i >= 32'(ptr_q))) begin
                gnt_any  = 1'b1;
                grant[i] = 1'b1;
                gnt_idx  = IdxW'(i);
            end
        end
        for (int unsigned i = 0; i < NB_CLIENTS; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any  = 1'b1;
                grant[i] = 1'b1;
                gnt_idx  = IdxW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == IdxW'(NB_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NB_CLIENTS; i++) begin
            if (grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Gating with the reset keeps req_ready low while the block is held in reset.
    assign req_ready = grant & {NB_CLIENTS{arst_n_in}};

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            ptr_q          <= '0;
            mem_en_q       <= 1'b0;
            mem_write_en_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            vld_q          <= '0;
            rdata_q        <= '0;
            for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q          <= ptr_d;
            mem_en_q       <= gnt_any;
            mem_write_en_q <= gnt_any & sel_write;
            if (gnt_any) begin
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_wdata;
            end
            vld_q    <= {vld_q[READ_LATENCY-1:0], gnt_any & ~sel_write};
            tag_q[0] <= gnt_idx;
            for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (vld_q[READ_LATENCY]) begin
                rdata_q <= mem_qout;
            end
        end
    end

    assign mem_en       = mem_en_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NB_CLIENTS; i++) begin
            rsp_valid[i] = vld_q[READ_LATENCY] && (tag_q[READ_LATENCY] == IdxW'(i));
        end
    end

    assign rsp_rdata = vld_q[READ_LATENCY] ? mem_qout : rdata_q;

`ifdef EXT_MEM_BW_COUNT_EN
    logic                 rd_hit, wr_hit;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    assign rd_hit = mem_en_q & ~mem_write_en_q;
    assign wr_hit = mem_en_q & mem_write_en_q;

    // Clear still counts an access on the port in the same cycle; counts saturate.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (bw_clear) begin
            rd_cnt_d = CNT_WIDTH'(rd_hit);
            wr_cnt_d = CNT_WIDTH'(wr_hit);
        end else begin
            if (rd_hit && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
            if (wr_hit && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign bw_read_words  = rd_cnt_q;
    assign bw_write_words = wr_cnt_q;
`else
    logic unused_bw_clear;
    assign unused_bw_clear = bw_clear;
    assign bw_read_words   = '0;
    assign bw_write_words  = '0;
`endif

endmodule

// File: doc/ext_mem_arbiter.md
# ext_mem_arbiter

Round-robin arbiter that multiplexes NB_CLIENTS request ports onto one single-port external memory. It sits between the accelerator core and the external memory in the system wrapper. It replaces the pseudo-2-port memory hookup with a single-port access: at most one read or write per cycle. It routes read data back to the issuing client and, optionally, counts external-memory traffic for bandwidth accounting.

## Interface
- NB_CLIENTS, 2, number of request ports (≥1)
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 20, memory address width
- READ_LATENCY, 1, cycles from mem_en to valid mem_qout (≥1)
- CNT_WIDTH, 32, bandwidth counter width
- clk  in  1  clock, all logic on rising edge
- arst_n_in  in  1  asynchronous reset, active low
- req_valid  in  NB_CLIENTS  per-client request valid
- req_ready  out  NB_CLIENTS  per-client grant (one-hot or zero)
- req_write  in  NB_CLIENTS  1 = write, 0 = read
- req_addr  in  NB_CLIENTS*ADDR_WIDTH  flattened addresses, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NB_CLIENTS*DATA_WIDTH  flattened write data
- rsp_valid  out  NB_CLIENTS  one-hot read-data-valid
- rsp_rdata  out  DATA_WIDTH  read data, shared by all clients
- mem_en  out  1  memory access this cycle
- mem_write_en  out  1  access is a write
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  memory write data
- mem_qout  in  DATA_WIDTH  memory read data
- bw_clear  in  1  synchronous clear of counters
- bw_read_words  out  CNT_WIDTH  reads issued since clear
- bw_write_words  out  CNT_WIDTH  writes issued since clear

## Operation
- Arbitration is combinational on req_valid and is held in rotating pointer p (reset 0).
- Grant goes to the first valid client at index p, p+1, … modulo NB_CLIENTS.
- req_ready[i] = grant[i]. The transfer occurs when req_valid[i] & req_ready[i].
- After a grant to client i, p ← (i+1) mod NB_CLIENTS. With no valid request, p is unchanged.
- req_ready is never asserted to a client whose req_valid is low.
- Accepted request is registered onto mem_en/mem_write_en/mem_addr/mem_din in the next cycle. When idle, mem_en = 0, mem_write_en = 0, and mem_addr/mem_din hold their last value.
- Reads push the granted client index into a tag shift pipe of depth 1+READ_LATENCY. The pipe emits rsp_valid[tag] with rsp_rdata = mem_qout.
- Writes produce no response.
- Responses have no back-pressure; clients must accept rsp_valid in that cycle.
- Responses return in issue order. Multiple outstanding reads (one per cycle) are supported.
- rsp_rdata holds its last value when rsp_valid = 0.

## Timing
- Request accepted in cycle t → mem_en high in t+1 → rsp_valid in t+1+READ_LATENCY (READ_LATENCY=1: 2 cycles).
- Throughput is one access per cycle: a continuously valid client is granted every cycle when alone. Under contention, each of k valid clients is granted once every k cycles.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, mem_en 0, mem_write_en 0, mem_addr 0, mem_din 0, counters 0, p 0.
- Reset mid-operation:
  - In-flight reads are discarded.
  - No rsp_valid is asserted until a new read completes after reset release.
- Read and write from different clients in the same cycle: only one is granted; the other waits. There is no read/write priority; only round-robin applies.
- Client deasserting req_valid without a handshake is allowed: the request is dropped and p is unaffected.

## Configuration
- Macro EXT_MEM_BW_COUNT_EN.
- Defined:
  - bw_read_words/bw_write_words increment in each cycle mem_en is high, selected by mem_write_en.
  - Counters saturate at 2^CNT_WIDTH−1.
  - When bw_clear is high, the counter is loaded with 0, or with 1 if an access of that type is on the memory port in the same cycle.
- Undefined: counters are tied to 0, no counter flops exist, and bw_clear is ignored.

## Test plan
- Single client, NB_CLIENTS=2. Client 0 writes 0xDEADBEEF to addr 5, then reads addr 5 → mem_en/mem_write_en=1 at t+1, then rsp_valid=2'b01 with rsp_rdata=0xDEADBEEF at read-accept+2.
- Both clients valid for 6 cycles → grants alternate 0,1,0,1,0,1. Each client gets 3 accesses. With client 0 idle, client 1 gets grants on consecutive cycles.
- NB_CLIENTS=4, READ_LATENCY=3, back-to-back reads from clients 2,3,0 on addrs holding 0x11,0x22,0x33 → rsp_valid 4'b0100, 4'b1000, 4'b0001 with data 0x11, 0x22, 0x33 on consecutive cycles starting 4 cycles after the first accept.
- Assert arst_n_in low while 2 reads are in flight → all outputs 0 immediately. No rsp_valid after release. p=0, so client 0 wins the first contention.
- With EXT_MEM_BW_COUNT_EN, CNT_WIDTH=4: 20 writes → bw_write_words=15 (saturated). bw_clear coincident with a write → 1. Without the macro → both counters read 0 throughout.
